// File: rtl/rom_download_streamer_if.sv
// Byte-stream input and 16-bit memory write port of the ROM download streamer.
// The streamer side uses master; the source/memory side uses slave.
interface rom_download_streamer_if #(
    parameter int ADDR_WIDTH = 25
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] addr;
    logic [15:0]           data;
    logic                  wr;
    logic                  wr_ack;

    modport master (
        input  in_valid, in_data, wr_ack,
        output in_ready, addr, data, wr
    );

    modport slave (
        output in_valid, in_data, wr_ack,
        input  in_ready, addr, data, wr
    );
endinterface

// File: rtl/rom_download_streamer.sv
// Packs a byte stream into 16-bit words and writes them to memory at
// consecutive even addresses, pulsing done when the whole file is in.
module rom_download_streamer #(
    parameter int ADDR_WIDTH = 25,
    parameter bit BYTE_SWAP  = 1'b0
) (
    input  logic                        clk_mem,
    input  logic                        reset,
    input  logic                        start,
    input  logic [31:0]                 file_size,
    rom_download_streamer_if.master     bus,
    output logic                        downloading,
    output logic [31:0]                 rom_file_size,
    output logic                        done
);
    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        WRITE,
        FINISH
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST =
        {{(ADDR_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(2);

    state_t      state;
    logic [31:0] count;
    logic [31:0] count_inc;
    logic [7:0]  first;
    logic        over;
    logic        xfer;

    assign count_inc = count + 32'd1;
    assign xfer      = bus.in_valid && bus.in_ready;

    function automatic logic [15:0] pack(
        input logic [7:0] lo,
        input logic [7:0] hi
    );
        return BYTE_SWAP ? {lo, hi} : {hi, lo};
    endfunction

    // Once the address space is exhausted, words are still assembled and
    // consumed but never written, so the stream drains to completion.
    always_ff @(posedge clk_mem or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            count         <= 32'd0;
            first         <= 8'h00;
            over          <= 1'b0;
            rom_file_size <= 32'd0;
            downloading   <= 1'b0;
            done          <= 1'b0;
            bus.addr      <= '0;
            bus.data      <= 16'h0000;
            bus.wr        <= 1'b0;
            bus.in_ready  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        rom_file_size <= file_size;
                        count         <= 32'd0;
                        over          <= 1'b0;
                        bus.addr      <= '0;
                        if (file_size != 32'd0) begin
                            state        <= LOW;
                            downloading  <= 1'b1;
                            bus.in_ready <= 1'b1;
                        end else begin
                            state <= FINISH;
                        end
                    end
                end
                LOW: begin
                    if (xfer) begin
                        first <= bus.in_data;
                        count <= count_inc;
                        if (count_inc == rom_file_size) begin
                            state        <= WRITE;
                            bus.in_ready <= 1'b0;
                            bus.data     <= pack(bus.in_data, 8'h00);
                            bus.wr       <= !over;
                        end else begin
                            state <= HIGH;
                        end
                    end
                end
                HIGH: begin
                    if (xfer) begin
                        count        <= count_inc;
                        state        <= WRITE;
                        bus.in_ready <= 1'b0;
                        bus.data     <= pack(first, bus.in_data);
                        bus.wr       <= !over;
                    end
                end
                WRITE: begin
                    if (bus.wr_ack || over) begin
                        bus.wr <= 1'b0;
                        if (count == rom_file_size) begin
                            state       <= FINISH;
                            downloading <= 1'b0;
                        end else begin
                            state        <= LOW;
                            bus.in_ready <= 1'b1;
                            if (over || bus.addr == ADDR_LAST)
                                over <= 1'b1;
                            else
                                bus.addr <= bus.addr + ADDR_STEP;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/rom_download_streamer.md
ROM_DOWNLOAD_STREAMER -- requirements
Module: rom_download_streamer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 25, width of byte address output addr.
REQ-002 SHALL have parameter BYTE_SWAP, default 0; 1 places first byte of each pair in data[15:8] instead of data[7:0].
REQ-003 SHALL have port clk_mem  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a download.
REQ-006 SHALL have port file_size  input  32  byte count of ROM file, sampled on accepted start.
REQ-007 SHALL have ports in_valid input 1, in_data input 8, in_ready output 1: byte stream, transfer when in_valid && in_ready.
REQ-008 SHALL have port addr  output  ADDR_WIDTH  byte address of low byte of current word.
REQ-009 SHALL have port data  output  16  packed word being written.
REQ-010 SHALL have port wr  output  1  write request, held until wr_ack.
REQ-011 SHALL have port wr_ack  input  1  memory accepted the word this cycle.
REQ-012 SHALL have port downloading  output  1  high while a download is in progress.
REQ-013 SHALL have port rom_file_size  output  32  latched file_size of last download.
REQ-014 SHALL have port done  output  1  one-cycle pulse at end of download.

Function
REQ-015 SHALL implement states IDLE, LOW, HIGH, WRITE, FINISH.
REQ-016 IDLE: start=1 latches file_size into rom_file_size, clears byte counter and addr to 0; go LOW if file_size!=0, else FINISH.
REQ-017 start SHALL be ignored in every state except IDLE.
REQ-018 downloading SHALL be 1 in LOW, HIGH, WRITE; 0 in IDLE and FINISH (registered, asserted the cycle after start accepted).
REQ-019 in_ready SHALL be 1 only in LOW and HIGH; never in WRITE.
REQ-020 LOW: byte transfer stores byte as first byte, increments byte counter; go HIGH unless counter now equals file_size, then go WRITE with second byte 0x00.
REQ-021 HIGH: byte transfer stores second byte, increments counter, go WRITE.
REQ-022 Packing (BYTE_SWAP=0): data = {second, first}; BYTE_SWAP=1: data = {first, second}.
REQ-023 WRITE: wr=1 with stable addr/data until wr_ack; on wr_ack go FINISH if counter==file_size, else addr += 2 and go LOW.
REQ-024 wr_ack outside WRITE SHALL be ignored; wr SHALL deassert the cycle after wr_ack.
REQ-025 Words whose addr would exceed 2^ADDR_WIDTH-2: bytes still consumed (in_ready=1), wr not asserted, addr holds; download completes normally.
REQ-026 FINISH: done=1 for exactly one cycle, then IDLE; addr holds last written word address until next start.
REQ-027 Byte counter SHALL be 32 bits; compare is exact equality with latched file_size.
REQ-028 in_data when in_valid=0 SHALL be ignored; stalls of any length permitted in LOW/HIGH.

Reset
REQ-029 reset SHALL force IDLE, addr=0, data=0, wr=0, downloading=0, in_ready=0, done=0, rom_file_size=0, counter=0, asynchronously and at any state.
REQ-030 Reset mid-download SHALL abandon partial word with no wr and no done pulse.

Verification
REQ-031 file_size=4, bytes 11,22,33,44, wr_ack immediate -> writes (addr 0, data 0x2211), (addr 2, data 0x4433); done one cycle after second ack; downloading low with done.
REQ-032 file_size=3, bytes AA,BB,CC -> writes (0,0xBBAA), (2,0x00CC); exactly 3 bytes consumed, in_ready low thereafter.
REQ-033 file_size=0, start -> no wr, downloading never high, done pulse 2 cycles after start.
REQ-034 wr_ack delayed 5 cycles, in_valid held high -> in_ready low and addr/data stable for all 5 WRITE cycles; no bytes lost.
REQ-035 reset asserted after first byte of file_size=8 -> all outputs zero immediately; new start with file_size=2 writes addr 0 correctly.
REQ-036 BYTE_SWAP=1, file_size=2, bytes 12,34 -> data 0x1234; start pulsed during download -> ignored, rom_file_size unchanged.
